// File: rtl/arcade_seq_pkg.sv
// Shared types and default constants for the arcade core sequencer.
// Imported by the sequencer top and by the benches.
package arcade_seq_pkg;

  typedef enum logic [1:0] {
    LOCK_WAIT,
    HOLD,
    RUN
  } seq_state_t;

  localparam int HOLD_CYCLES_DEF = 256;
  localparam int AUD_NUM_DEF     = 1;
  localparam int AUD_DEN_DEF     = 14;

endpackage

// File: rtl/arcade_frac_ce.sv
// Phase-accumulator clock enable: average rate clk_sys*NUM/DEN.
// Requires 0 < NUM < DEN and DEN + NUM < 2**W.
module arcade_frac_ce #(
  parameter int NUM = 1,
  parameter int DEN = 14,
  parameter int W   = 8
) (
  input  logic clk_sys,
  input  logic res_n,
  output logic ce
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;
  logic [W-1:0] sum;
  logic         ce_q;
  logic         ce_d;

  always_comb begin
    sum   = acc_q + W'(NUM);
    acc_d = sum;
    ce_d  = 1'b0;
    if (sum >= W'(DEN)) begin
      acc_d = sum - W'(DEN);
      ce_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/arcade_core_sequencer.sv
// Pixel/audio clock-enable generation and PLL-lock/reset sequencing
// for an arcade game core.
module arcade_core_sequencer
  import arcade_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int AUD_NUM     = AUD_NUM_DEF,
  parameter int AUD_DEN     = AUD_DEN_DEF,
  parameter int ACC_W       = 8
) (
  input  logic clk_sys,
  input  logic res_n,
  input  logic pll_locked,
  input  logic rst_req,
  output logic ce_12,
  output logic ce_6p,
  output logic ce_6n,
  output logic ce_aud,
  output logic core_reset,
  output logic core_run
);

  // hcnt must hold HOLD_CYCLES itself (reload value)
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic [1:0]    div_q;
  logic [1:0]    div_d;
  logic          ce_12_q, ce_12_d;
  logic          ce_6p_q, ce_6p_d;
  logic          ce_6n_q, ce_6n_d;
  logic          lock_m_q;
  logic          lock_s_q;
  seq_state_t    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          core_reset_q, core_reset_d;
  logic          core_run_q, core_run_d;

  always_comb begin
    div_d   = div_q + 2'd1;
    ce_12_d = div_q[0];
    ce_6p_d = (div_q == 2'd1);
    ce_6n_d = (div_q == 2'd3);
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      LOCK_WAIT: begin
        if (lock_s_q) begin
          state_d = HOLD;
          hcnt_d  = HW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (!lock_s_q) begin
          state_d = LOCK_WAIT;
        end else if (rst_req) begin
          hcnt_d = HW'(HOLD_CYCLES);
        end else if (hcnt_q == '0) begin
          state_d = RUN;
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = LOCK_WAIT;
        end else if (rst_req) begin
          state_d = HOLD;
          hcnt_d  = HW'(HOLD_CYCLES);
        end
      end
      default: state_d = LOCK_WAIT;
    endcase
    core_reset_d = (state_d != RUN);
    core_run_d   = (state_d == RUN);
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      div_q        <= '0;
      ce_12_q      <= 1'b0;
      ce_6p_q      <= 1'b0;
      ce_6n_q      <= 1'b0;
      lock_m_q     <= 1'b0;
      lock_s_q     <= 1'b0;
      state_q      <= LOCK_WAIT;
      hcnt_q       <= '0;
      core_reset_q <= 1'b1;
      core_run_q   <= 1'b0;
    end else begin
      div_q        <= div_d;
      ce_12_q      <= ce_12_d;
      ce_6p_q      <= ce_6p_d;
      ce_6n_q      <= ce_6n_d;
      lock_m_q     <= pll_locked;
      lock_s_q     <= lock_m_q;
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      core_reset_q <= core_reset_d;
      core_run_q   <= core_run_d;
    end
  end

  arcade_frac_ce #(
    .NUM (AUD_NUM),
    .DEN (AUD_DEN),
    .W   (ACC_W)
  ) u_aud_ce (
    .clk_sys (clk_sys),
    .res_n   (res_n),
    .ce      (ce_aud)
  );

  assign ce_12      = ce_12_q;
  assign ce_6p      = ce_6p_q;
  assign ce_6n      = ce_6n_q;
  assign core_reset = core_reset_q;
  assign core_run   = core_run_q;

endmodule

// File: tb/tb_arcade_core_sequencer.sv
// Directed bench for arcade_core_sequencer: enables, audio rate,
// lock/hold sequencing, reset requests and async reset.
module tb_arcade_core_sequencer;
  import arcade_seq_pkg::*;

  logic clk;
  logic res_n;
  logic pll_locked;
  logic rst_req;
  logic ce_12, ce_6p, ce_6n, ce_aud;
  logic core_reset, core_run;
  logic a_ce_12, a_ce_6p, a_ce_6n, a_ce_aud;
  logic a_core_reset, a_core_run;

  int total;
  int bad;

  arcade_core_sequencer #(
    .HOLD_CYCLES (8),
    .AUD_NUM     (1),
    .AUD_DEN     (14),
    .ACC_W       (8)
  ) u_dut (
    .clk_sys    (clk),
    .res_n      (res_n),
    .pll_locked (pll_locked),
    .rst_req    (rst_req),
    .ce_12      (ce_12),
    .ce_6p      (ce_6p),
    .ce_6n      (ce_6n),
    .ce_aud     (ce_aud),
    .core_reset (core_reset),
    .core_run   (core_run)
  );

  arcade_core_sequencer #(
    .HOLD_CYCLES (8),
    .AUD_NUM     (3),
    .AUD_DEN     (40),
    .ACC_W       (8)
  ) u_aud (
    .clk_sys    (clk),
    .res_n      (res_n),
    .pll_locked (pll_locked),
    .rst_req    (rst_req),
    .ce_12      (a_ce_12),
    .ce_6p      (a_ce_6p),
    .ce_6n      (a_ce_6n),
    .ce_aud     (a_ce_aud),
    .core_reset (a_core_reset),
    .core_run   (a_core_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic lock);
    res_n      = 1'b0;
    pll_locked = lock;
    rst_req    = 1'b0;
    tick();
    tick();
    chk("rst_ce12", 32'(ce_12), 0);
    chk("rst_ce6p", 32'(ce_6p), 0);
    chk("rst_ce6n", 32'(ce_6n), 0);
    chk("rst_aud", 32'(ce_aud), 0);
    chk("rst_creset", 32'(core_reset), 1);
    chk("rst_crun", 32'(core_run), 0);
    res_n = 1'b1;
  endtask

  initial begin
    int n12, n6p, n6n, ovl, last6p, last, n14, n40;
    int fall;
    int cnt;
    bit found;
    total      = 0;
    bad        = 0;
    res_n      = 1'b0;
    pll_locked = 1'b0;
    rst_req    = 1'b0;

    // divider pattern and counts over 64 clocks
    do_reset(1'b1);
    n12 = 0; n6p = 0; n6n = 0; ovl = 0; last6p = -100;
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (e == 1) chk("e1_ce12", 32'(ce_12), 0);
      if (e == 2) begin
        chk("e2_ce12", 32'(ce_12), 1);
        chk("e2_ce6p", 32'(ce_6p), 1);
      end
      if (e == 4) begin
        chk("e4_ce12", 32'(ce_12), 1);
        chk("e4_ce6n", 32'(ce_6n), 1);
      end
      if (ce_12) n12++;
      if (ce_6p) begin n6p++; last6p = e; end
      if (ce_6n) begin
        n6n++;
        chk("6n_after_6p", 32'(e - last6p), 2);
      end
      if (ce_6p && ce_6n) ovl++;
    end
    chk("n_ce12", 32'(n12), 32);
    chk("n_ce6p", 32'(n6p), 16);
    chk("n_ce6n", 32'(n6n), 16);
    chk("overlap", 32'(ovl), 0);

    // fractional audio enable
    do_reset(1'b0);
    n14 = 0; n40 = 0; last = 0;
    for (int e = 1; e <= 4000; e++) begin
      tick();
      if (e <= 1400 && ce_aud) begin
        n14++;
        chk("aud_gap", 32'(e - last), 14);
        last = e;
      end
      if (a_ce_aud) n40++;
    end
    chk("n_aud14", 32'(n14), 100);
    chk("n_aud40", 32'(n40), 300);

    // lock latency: pll_locked rises after edge 10
    do_reset(1'b0);
    fall = 0;
    found = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (e == 10) pll_locked = 1'b1;
      if (!found && !core_reset) begin
        found = 1'b1;
        fall  = e;
        chk("run_with_fall", 32'(core_run), 1);
      end
    end
    chk("lock_fall_edge", 32'(fall), 21);

    // one-clock reset request in RUN
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    cnt = 0;
    for (int e = 0; e < 50 && core_reset; e++) begin
      cnt++;
      tick();
    end
    chk("pulse_hold_len", 32'(cnt), 9);
    chk("pulse_back_run", 32'(core_run), 1);

    // reset request held 20 clocks
    rst_req = 1'b1;
    for (int e = 0; e < 20; e++) tick();
    chk("held_in_reset", 32'(core_reset), 1);
    rst_req = 1'b0;
    cnt = 0;
    found = 1'b0;
    for (int e = 1; e <= 50 && !found; e++) begin
      tick();
      if (!core_reset) begin
        found = 1'b1;
        cnt   = e;
      end
    end
    chk("held_release", 32'(cnt), 9);

    // lock loss while in HOLD
    rst_req = 1'b1;
    tick();
    rst_req    = 1'b0;
    pll_locked = 1'b0;
    tick();
    tick();
    tick();
    chk("hold_loss_state", 32'(u_dut.state_q), 32'(LOCK_WAIT));
    chk("hold_loss_reset", 32'(core_reset), 1);

    // lock loss in RUN coinciding with a reset request
    pll_locked = 1'b1;
    found = 1'b0;
    for (int e = 0; e < 100 && !found; e++) begin
      tick();
      if (core_run) found = 1'b1;
    end
    chk("relock_run", 32'(found), 1);
    pll_locked = 1'b0;
    tick();
    tick();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    chk("loss_beats_req", 32'(u_dut.state_q), 32'(LOCK_WAIT));
    chk("loss_run", 32'(core_run), 0);
    chk("loss_reset", 32'(core_reset), 1);

    // asynchronous reset mid-HOLD
    do_reset(1'b1);
    for (int e = 0; e < 6; e++) tick();
    chk("pre_hold", 32'(u_dut.state_q), 32'(HOLD));
    chk("pre_ce12", 32'(ce_12), 1);
    #2;
    res_n = 1'b0;
    #1;
    chk("async_ce12", 32'(ce_12), 0);
    chk("async_ce6p", 32'(ce_6p), 0);
    chk("async_ce6n", 32'(ce_6n), 0);
    chk("async_creset", 32'(core_reset), 1);
    chk("async_crun", 32'(core_run), 0);
    chk("async_state", 32'(u_dut.state_q), 32'(LOCK_WAIT));
    res_n = 1'b1;
    tick();
    chk("re1_ce12", 32'(ce_12), 0);
    chk("re1_ce6p", 32'(ce_6p), 0);
    tick();
    chk("re2_ce12", 32'(ce_12), 1);
    chk("re2_ce6p", 32'(ce_6p), 1);
    tick();
    chk("re3_ce12", 32'(ce_12), 0);
    tick();
    chk("re4_ce12", 32'(ce_12), 1);
    chk("re4_ce6n", 32'(ce_6n), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
